// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 raster timing and the lock/scan FSM states
//               shared by the VGA timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  // Horizontal timing in pixel clocks
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Vertical timing in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Clocks of continuous synchronized lock before scanning starts
  localparam int VGA_LOCK_WAIT = 16;

  // Start-up / scan state machine
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous level signal.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; second flop gives a clean level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster timing generator. Waits for a stable PLL lock, then
//               produces registered hsync/vsync, data-enable, pixel
//               coordinates and line/frame strobes, all mutually aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = VGA_H_ACTIVE,
  parameter int   H_FP      = VGA_H_FP,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BP      = VGA_H_BP,
  parameter int   V_ACTIVE  = VGA_V_ACTIVE,
  parameter int   V_FP      = VGA_V_FP,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BP      = VGA_V_BP,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   LOCK_WAIT = VGA_LOCK_WAIT,
  localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW        = $clog2(H_TOTAL),
  localparam int  YW        = $clog2(V_TOTAL)
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  // Raster boundaries at counter width so all compares are unsigned
  localparam logic [XW-1:0] c_h_last     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] c_h_active   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] c_hs_start   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] c_hs_end     = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] c_v_last     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] c_v_active   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] c_vs_start   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] c_vs_end     = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] c_settle_end = CW'(LOCK_WAIT - 1);

  logic          w_lock_s;
  logic          w_run_ok;
  logic          w_de;
  logic          w_hs_act;
  logic          w_vs_act;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [XW-1:0] r_h;
  logic [YW-1:0] r_v;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_line_start;
  logic          r_frame_start;
  logic          r_running;

  sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .i_d (pll_locked),
    .o_q (w_lock_s)
  );

  // Scanning only while in RUN with lock still present; losing lock idles
  // the counters and outputs on the same clock the FSM leaves RUN.
  assign w_run_ok = (r_state == RUN) && w_lock_s;
  assign w_de     = (r_h < c_h_active) && (r_v < c_v_active);
  assign w_hs_act = (r_h >= c_hs_start) && (r_h < c_hs_end);
  assign w_vs_act = (r_v >= c_vs_start) && (r_v < c_vs_end);

  // Lock qualification FSM: r_cnt counts consecutive locked clocks,
  // including the clock on which WAIT_LOCK first sees the lock.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          r_cnt <= '0;
          if (w_lock_s) begin
            if (LOCK_WAIT <= 1) begin
              r_state <= RUN;
            end else begin
              r_state <= SETTLE;
              r_cnt   <= CW'(1);
            end
          end
        end
        SETTLE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt >= c_settle_end) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RUN: begin
          r_cnt <= '0;
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Horizontal/vertical position counters; held at 0 outside of scanning
  always_ff @(posedge refclk) begin
    if (rst || !w_run_ok) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == c_h_last) begin
      r_h <= '0;
      r_v <= (r_v == c_v_last) ? '0 : r_v + YW'(1);
    end else begin
      r_h <= r_h + XW'(1);
    end
  end

  // Registered outputs decoded from the counters (one clock latency)
  always_ff @(posedge refclk) begin
    if (rst || !w_run_ok) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      r_de          <= w_de;
      r_x           <= w_de ? r_h : '0;
      r_y           <= w_de ? r_v : '0;
      r_line_start  <= (r_h == '0);
      r_frame_start <= (r_h == '0) && (r_v == '0);
      r_running     <= 1'b1;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign running     = r_running;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen using a reduced raster
//               geometry so that whole frames stay short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HA = 40, HF = 4, HS = 8, HB = 6;
  localparam int VA = 30, VF = 3, VS = 2, VB = 5;
  localparam int LW = 16;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int LOCK_LAT = 2 + LW + 1;
  localparam int DROP_H = 20;
  localparam int DROP_V = 10;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          ls;
    logic          fs;
    logic          run;
  } out_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          hsync, vsync, de, line_start, frame_start, running;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  always #20 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL (1'b0), .VS_POL (1'b0), .LOCK_WAIT (LW)
  ) dut (
    .refclk      (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .running     (running)
  );

  function automatic out_t idle_out();
    out_t o;
    o     = '0;
    o.hs  = 1'b1;
    o.vs  = 1'b1;
    return o;
  endfunction

  // Expected registered outputs for counter position (h, v) while scanning
  function automatic out_t exp_run(int h, int v);
    out_t o;
    o     = '0;
    o.de  = (h < HA) && (v < VA);
    o.x   = o.de ? XW'(h) : '0;
    o.y   = o.de ? YW'(v) : '0;
    o.hs  = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
    o.vs  = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    o.run = 1'b1;
    return o;
  endfunction

  function automatic out_t cur();
    out_t o;
    o.hs = hsync; o.vs = vsync; o.de = de; o.x = x; o.y = y;
    o.ls = line_start; o.fs = frame_start; o.run = running;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts clocks until the first frame_start; flags any activity before it
  task automatic wait_first_frame(output int n, output bit stray);
    n = -1;
    stray = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (frame_start) begin
        n = i;
        break;
      end
      if (running || line_start || de) stray = 1'b1;
    end
  endtask

  task automatic test_reset();
    out_t a;
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) tick();
    a = cur();
    n_checks++;
    if (a !== idle_out()) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", a, idle_out());
    end
    rst = 1'b0;
  endtask

  task automatic test_no_lock();
    out_t a;
    int bad = 0;
    repeat (1000) begin
      tick();
      a = cur();
      if (a !== idle_out()) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_lock_idle non_idle_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_lock_latency();
    int n;
    bit stray;
    out_t a;
    pll_locked = 1'b1;
    wait_first_frame(n, stray);
    n_checks++;
    if (n != LOCK_LAT) begin
      n_fail++;
      $display("FAIL lock_latency got=%0d exp=%0d", n, LOCK_LAT);
    end
    n_checks++;
    if (stray) begin
      n_fail++;
      $display("FAIL lock_stray got=1 exp=0");
    end
    a = cur();
    n_checks++;
    if (a !== exp_run(0, 0)) begin
      n_fail++;
      $display("FAIL first_frame_out got=%h exp=%h", a, exp_run(0, 0));
    end
  endtask

  // Scoreboard over one full frame following the frame_start just seen
  task automatic test_frame();
    out_t q[$];
    out_t a, e;
    int idx = 0;
    int bad = 0;
    int de_lines = 0, de_l1 = 0, hs_l1 = 0, hs_first = -1;
    int vs_cnt = 0, vs_first = -1, fs_idx = -1;
    for (int i = 1; i <= HT * VT; i++) q.push_back(exp_run(i % HT, (i / HT) % VT));
    while (q.size() > 0) begin
      tick();
      idx++;
      e = q.pop_front();
      a = cur();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        bad++;
        if (bad <= 20) $display("FAIL frame_out idx=%0d got=%h exp=%h", idx, a, e);
      end
      if (de && x == XW'(HA - 1)) de_lines++;
      if (idx >= HT && idx < 2 * HT) begin
        if (de) de_l1++;
        if (!hsync) begin
          hs_l1++;
          if (hs_first < 0) hs_first = idx - HT;
        end
      end
      if (!vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = idx;
      end
      if (frame_start && fs_idx < 0) fs_idx = idx;
    end
    n_checks++;
    if (fs_idx != HT * VT) begin
      n_fail++;
      $display("FAIL frame_period got=%0d exp=%0d", fs_idx, HT * VT);
    end
    n_checks++;
    if (de_lines != VA) begin
      n_fail++;
      $display("FAIL de_lines got=%0d exp=%0d", de_lines, VA);
    end
    n_checks++;
    if (de_l1 != HA) begin
      n_fail++;
      $display("FAIL de_per_line got=%0d exp=%0d", de_l1, HA);
    end
    n_checks++;
    if (hs_l1 != HS || hs_first != HA + HF) begin
      n_fail++;
      $display("FAIL hsync_window got=%0d@%0d exp=%0d@%0d", hs_l1, hs_first, HS, HA + HF);
    end
    n_checks++;
    if (vs_cnt != VS * HT || vs_first != (VA + VF) * HT) begin
      n_fail++;
      $display("FAIL vsync_window got=%0d@%0d exp=%0d@%0d", vs_cnt, vs_first, VS * HT, (VA + VF) * HT);
    end
  endtask

  task automatic test_lock_drop();
    bit found = 1'b0;
    int n;
    bit stray;
    out_t a;
    for (int i = 0; i < HT * VT + 10; i++) begin
      tick();
      if (de && x == XW'(DROP_H) && y == YW'(DROP_V)) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL drop_point_timeout got=0 exp=1");
    end
    pll_locked = 1'b0;
    tick();
    tick();
    n_checks++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_sync_delay running got=%b exp=1", running);
    end
    tick();
    a = cur();
    n_checks++;
    if (a !== idle_out()) begin
      n_fail++;
      $display("FAIL drop_idle got=%h exp=%h", a, idle_out());
    end
    repeat (5) tick();
    pll_locked = 1'b1;
    wait_first_frame(n, stray);
    n_checks++;
    if (n != LOCK_LAT || stray) begin
      n_fail++;
      $display("FAIL relock_latency got=%0d stray=%0b exp=%0d stray=0", n, stray, LOCK_LAT);
    end
    a = cur();
    n_checks++;
    if (a !== exp_run(0, 0)) begin
      n_fail++;
      $display("FAIL relock_origin got=%h exp=%h", a, exp_run(0, 0));
    end
  endtask

  task automatic test_rst_midframe();
    bit found = 1'b0;
    int n;
    bit stray;
    out_t a;
    for (int i = 0; i < HT * VT + 10; i++) begin
      tick();
      if (de && x == XW'(HA - 1) && y == YW'(VA - 1)) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rst_point_timeout got=0 exp=1");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a = cur();
    n_checks++;
    if (a !== idle_out()) begin
      n_fail++;
      $display("FAIL rst_idle got=%h exp=%h", a, idle_out());
    end
    wait_first_frame(n, stray);
    n_checks++;
    if (n != LOCK_LAT) begin
      n_fail++;
      $display("FAIL rst_relock_latency got=%0d exp=%0d", n, LOCK_LAT);
    end
    n_checks++;
    if (stray) begin
      n_fail++;
      $display("FAIL rst_stray_line_start got=1 exp=0");
    end
  endtask

  initial begin
    test_reset();
    test_no_lock();
    test_lock_latency();
    test_frame();
    test_lock_drop();
    test_rst_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
